accel_host_driver: RTL and testbench
====================================

# accel_host_driver

Host-side initiator for the binarized CNN accelerator `top`. It streams conv1, conv2 and FC weight words from a host byte stream into the accelerator's kernel-write port. It then presents one 28x28 binary image with a valid/ready handshake and collects the 4-bit class result. It also measures inference latency and flags a timeout.

## Interface
Parameters:
- bW, 8, kernel word width (matches accelerator `kernel_offset`)
- L1_WORDS, 90, conv1 kernel writes (18*5)
- L2_WORDS, 1080, conv2 kernel writes (18*60)
- FC_WORDS, 960, FC weight writes
- TIMEOUT, 4095, max cycles waiting for class after image accepted

Ports (reset is asynchronous and active-high):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to run one inference
- skip_load  in  1  sampled with start; reuse already-loaded weights
- img_data  in  784  flattened image, bit y*28+x = pixel [y][x]; sampled on accepted start
- w_valid  in  1  host weight stream valid
- w_ready  out  1  host weight stream ready
- w_data  in  bW  host weight word
- kernel_in_valid  out  1  accelerator kernel write strobe
- kernel_offset  out  bW  kernel word
- kernel_addr  out  11  word index within layer
- kernel_layer  out  2  1=conv1, 2=conv2, 3=fc
- image_in_valid  out  1  image valid to accelerator
- image_in_ready  in  1  accelerator image ready
- image  out  784  registered image to accelerator
- class_out_valid  in  1  accelerator class valid
- class_out_ready  out  1  accept class
- class_out  in  4  accelerator class
- busy  out  1  FSM not in IDLE
- weights_loaded  out  1  all three layers written since reset
- result_valid  out  1  one-cycle pulse with result
- result_class  out  4  captured class
- result_cycles  out  16  cycles from image handshake to class handshake, saturating
- timeout_err  out  1  one-cycle pulse on timeout

## Operation
- States: IDLE, LOAD1, LOAD2, LOADFC, SEND_IMG, WAIT_CLASS.
- IDLE:
  - start=1 captures img_data into `image`.
  - Next state is SEND_IMG if skip_load=1 and weights_loaded=1; otherwise LOAD1.
  - start is ignored in any other state.
- LOADn states:
  - w_ready=1. The accelerator kernel port is always ready.
  - Each beat with w_valid&w_ready is registered onto the kernel_* outputs for exactly one cycle: kernel_in_valid=1, kernel_offset=w_data, kernel_addr=word counter, kernel_layer=n (1, 2, 3).
  - The word counter increments per beat.
  - On the last beat of a layer (counter = WORDS-1), the counter clears to 0 and the FSM advances: LOAD1 -> LOAD2 -> LOADFC -> SEND_IMG.
  - The last FC beat sets weights_loaded=1.
  - Host stalls (w_valid=0) insert idle cycles with kernel_in_valid=0. No word is dropped or duplicated.
- SEND_IMG:
  - image_in_valid=1, held with `image` stable until image_in_ready=1 in the same cycle.
  - After the handshake: image_in_valid=0, latency counter cleared, go to WAIT_CLASS.
- WAIT_CLASS:
  - class_out_ready=1. The latency counter increments every cycle, saturating at 16'hFFFF.
  - On class_out_valid: result_class<=class_out, result_cycles<=counter+1 (saturated), result_valid pulses, go to IDLE.
  - If the counter reaches TIMEOUT before class_out_valid: timeout_err pulses, result_valid stays 0, go to IDLE. weights_loaded is unchanged.
- Reset mid-operation: FSM returns to IDLE and all counters clear. weights_loaded=0, so the next start reloads regardless of skip_load.

## Timing
- All outputs are registered.
- Reset values: every output is 0, including image and result_class.
- result_class and result_cycles hold their values until the next capture.
- start at edge k -> busy=1 at k+1.
- Load path:
  - A beat accepted at edge k drives kernel_in_valid=1 during cycle k+1.
  - Full load with no stalls takes L1_WORDS+L2_WORDS+FC_WORDS cycles of w_ready.
- The cycle after the last FC beat has image_in_valid=1 (SEND_IMG). The last kernel write occurs in that same cycle.
- Image path:
  - With skip_load, image_in_valid=1 one cycle after start.
  - If image_in_ready is already high, the handshake completes in that cycle.
- result_valid is asserted the cycle after the class handshake.
- result_valid and timeout_err are mutually exclusive. If class_out_valid arrives on the timeout cycle, the class wins.
- busy=0 in the same cycle that result_valid or timeout_err is high.

## Test plan
Bench parameters unless stated: L1_WORDS=3, L2_WORDS=4, FC_WORDS=2, TIMEOUT=20.
- Reset then start with w_valid=1 and words 1..9 -> writes (layer,addr,offset) = (1,0,1),(1,1,2),(1,2,3),(2,0,4)...(2,3,7),(3,0,8),(3,1,9); weights_loaded=1; image_in_valid rises the next cycle.
- Host stalls: w_valid toggled every other cycle -> same 9 writes, no gaps in kernel_addr, kernel_in_valid=0 on stall cycles.
- skip_load=1 after a load; image_in_ready low for 3 cycles; class_out_valid=1 with class_out=7 five cycles after the handshake -> no kernel writes, image stable while waiting, result_class=7, result_cycles=5.
- class_out_valid never asserted -> timeout_err pulse 20 cycles after the handshake, result_valid=0, busy=0.
- Assert rst during LOAD2, then start with skip_load=1 -> weights_loaded=0 and the full reload begins at LOAD1 addr 0.
- start pulsed while in WAIT_CLASS with a different img_data -> ignored; image unchanged; one result only.

Source files
------------

// File: rtl/accel_host_driver.sv
// accel_host_driver
//   Host-side initiator for the binarized CNN accelerator. The driver does
//   three jobs in turn:
//     1. Streams the conv1, conv2 and FC weight words from a host
//        valid/ready stream into the accelerator kernel-write port.
//     2. Presents one captured 28x28 binary image with a valid/ready
//        handshake.
//     3. Collects the 4-bit class result and measures the inference
//        latency, flagging a timeout if the result never arrives.
//   All outputs are registered. Reset is asynchronous and active-high.
//
// Ports
//   clk, rst                          clock, async active-high reset
//   start, skip_load, img_data        run request, weight reuse, image
//   w_valid/w_ready/w_data            host weight stream
//   kernel_in_valid/offset/addr/layer accelerator kernel write port
//   image_in_valid/ready, image       accelerator image handshake
//   class_out_valid/ready, class_out  accelerator class handshake
//   busy, weights_loaded              status
//   result_valid/class/cycles         inference result
//   timeout_err                       one-cycle timeout pulse
module accel_host_driver #(
    parameter int bW       = 8,
    parameter int L1_WORDS = 90,
    parameter int L2_WORDS = 1080,
    parameter int FC_WORDS = 960,
    parameter int TIMEOUT  = 4095
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          skip_load,
    input  logic [783:0]  img_data,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [bW-1:0] w_data,
    output logic          kernel_in_valid,
    output logic [bW-1:0] kernel_offset,
    output logic [10:0]   kernel_addr,
    output logic [1:0]    kernel_layer,
    output logic          image_in_valid,
    input  logic          image_in_ready,
    output logic [783:0]  image,
    input  logic          class_out_valid,
    output logic          class_out_ready,
    input  logic [3:0]    class_out,
    output logic          busy,
    output logic          weights_loaded,
    output logic          result_valid,
    output logic [3:0]    result_class,
    output logic [15:0]   result_cycles,
    output logic          timeout_err
);

    localparam logic [10:0] L1_LAST     = 11'(L1_WORDS - 1);
    localparam logic [10:0] L2_LAST     = 11'(L2_WORDS - 1);
    localparam logic [10:0] FC_LAST     = 11'(FC_WORDS - 1);
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD1,
        LOAD2,
        LOADFC,
        SEND_IMG,
        WAIT_CLASS
    } state_t;

    state_t      state;
    logic [10:0] word_cnt;
    logic [15:0] lat_cnt;

    // Per-layer decode of the current load state.
    logic [10:0] layer_last;
    logic [1:0]  layer_code;
    logic        word_last;
    logic [15:0] lat_next;

    always_comb begin
        layer_last = L1_LAST;
        layer_code = 2'd1;
        case (state)
            LOAD2: begin
                layer_last = L2_LAST;
                layer_code = 2'd2;
            end
            LOADFC: begin
                layer_last = FC_LAST;
                layer_code = 2'd3;
            end
            default: begin
                layer_last = L1_LAST;
                layer_code = 2'd1;
            end
        endcase
        word_last = (word_cnt == layer_last);
        // Latency counter saturates rather than wrapping.
        lat_next  = (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            word_cnt        <= '0;
            lat_cnt         <= '0;
            w_ready         <= 1'b0;
            kernel_in_valid <= 1'b0;
            kernel_offset   <= '0;
            kernel_addr     <= '0;
            kernel_layer    <= '0;
            image_in_valid  <= 1'b0;
            image           <= '0;
            class_out_ready <= 1'b0;
            busy            <= 1'b0;
            weights_loaded  <= 1'b0;
            result_valid    <= 1'b0;
            result_class    <= '0;
            result_cycles   <= '0;
            timeout_err     <= 1'b0;
        end else begin
            kernel_in_valid <= 1'b0;
            result_valid    <= 1'b0;
            timeout_err     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        image <= img_data;
                        busy  <= 1'b1;
                        if (skip_load && weights_loaded) begin
                            state          <= SEND_IMG;
                            image_in_valid <= 1'b1;
                        end else begin
                            state    <= LOAD1;
                            w_ready  <= 1'b1;
                            word_cnt <= '0;
                        end
                    end
                end

                LOAD1, LOAD2, LOADFC: begin
                    // w_ready is held high throughout the load states, so a
                    // beat is simply w_valid.
                    if (w_valid) begin
                        kernel_in_valid <= 1'b1;
                        kernel_offset   <= w_data;
                        kernel_addr     <= word_cnt;
                        kernel_layer    <= layer_code;
                        if (word_last) begin
                            word_cnt <= '0;
                            case (state)
                                LOAD1:   state <= LOAD2;
                                LOAD2:   state <= LOADFC;
                                default: begin
                                    state          <= SEND_IMG;
                                    w_ready        <= 1'b0;
                                    image_in_valid <= 1'b1;
                                    weights_loaded <= 1'b1;
                                end
                            endcase
                        end else begin
                            word_cnt <= word_cnt + 11'd1;
                        end
                    end
                end

                SEND_IMG: begin
                    if (image_in_ready) begin
                        image_in_valid  <= 1'b0;
                        class_out_ready <= 1'b1;
                        lat_cnt         <= '0;
                        state           <= WAIT_CLASS;
                    end
                end

                WAIT_CLASS: begin
                    // A class arriving on the timeout cycle takes priority.
                    if (class_out_valid) begin
                        result_class    <= class_out;
                        result_cycles   <= lat_next;
                        result_valid    <= 1'b1;
                        class_out_ready <= 1'b0;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end else if (lat_next >= TIMEOUT_CNT) begin
                        timeout_err     <= 1'b1;
                        class_out_ready <= 1'b0;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        lat_cnt <= lat_next;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_host_driver.sv
// tb_accel_host_driver
//   Directed bench for accel_host_driver with small layer sizes
//   (3/4/2 words) and TIMEOUT=20. Outputs are sampled 1 ns after each
//   rising edge; inputs are changed at the same point.
module tb_accel_host_driver;

    logic          clk;
    logic          rst;
    logic          start;
    logic          skip_load;
    logic [783:0]  img_data;
    logic          w_valid;
    logic          w_ready;
    logic [7:0]    w_data;
    logic          kernel_in_valid;
    logic [7:0]    kernel_offset;
    logic [10:0]   kernel_addr;
    logic [1:0]    kernel_layer;
    logic          image_in_valid;
    logic          image_in_ready;
    logic [783:0]  image;
    logic          class_out_valid;
    logic          class_out_ready;
    logic [3:0]    class_out;
    logic          busy;
    logic          weights_loaded;
    logic          result_valid;
    logic [3:0]    result_class;
    logic [15:0]   result_cycles;
    logic          timeout_err;

    int n_checks = 0;
    int n_fails  = 0;

    logic [783:0] img_a;
    logic [783:0] img_b;
    logic [783:0] img_c;
    logic [783:0] img_d;

    accel_host_driver #(
        .bW       (8),
        .L1_WORDS (3),
        .L2_WORDS (4),
        .FC_WORDS (2),
        .TIMEOUT  (20)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .skip_load       (skip_load),
        .img_data        (img_data),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .w_data          (w_data),
        .kernel_in_valid (kernel_in_valid),
        .kernel_offset   (kernel_offset),
        .kernel_addr     (kernel_addr),
        .kernel_layer    (kernel_layer),
        .image_in_valid  (image_in_valid),
        .image_in_ready  (image_in_ready),
        .image           (image),
        .class_out_valid (class_out_valid),
        .class_out_ready (class_out_ready),
        .class_out       (class_out),
        .busy            (busy),
        .weights_loaded  (weights_loaded),
        .result_valid    (result_valid),
        .result_class    (result_class),
        .result_cycles   (result_cycles),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_img(input string tag, input logic [783:0] obs, input logic [783:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected (layer, addr) for the i-th weight word of a 3/4/2 load.
    task automatic chk_write(input string tag, input int i);
        int el;
        int ea;
        if (i <= 3) begin
            el = 1;
            ea = i - 1;
        end else if (i <= 7) begin
            el = 2;
            ea = i - 4;
        end else begin
            el = 3;
            ea = i - 8;
        end
        chk({tag, " kvalid"}, 32'(kernel_in_valid), 1);
        chk({tag, " layer"},  32'(kernel_layer), el);
        chk({tag, " addr"},   32'(kernel_addr), ea);
        chk({tag, " offset"}, 32'(kernel_offset), i);
    endtask

    initial begin
        img_a = {98{8'hA5}};
        img_b = {49{16'h1234}};
        img_c = {196{4'hC}};
        img_d = {98{8'h3C}};

        rst             = 1'b1;
        start           = 1'b0;
        skip_load       = 1'b0;
        img_data        = '0;
        w_valid         = 1'b0;
        w_data          = '0;
        image_in_ready  = 1'b0;
        class_out_valid = 1'b0;
        class_out       = '0;
        #12;

        // ---- reset state
        chk("rst busy",     32'(busy), 0);
        chk("rst w_ready",  32'(w_ready), 0);
        chk("rst kvalid",   32'(kernel_in_valid), 0);
        chk("rst kaddr",    32'(kernel_addr), 0);
        chk("rst ivalid",   32'(image_in_valid), 0);
        chk("rst cready",   32'(class_out_ready), 0);
        chk("rst wloaded",  32'(weights_loaded), 0);
        chk("rst rvalid",   32'(result_valid), 0);
        chk("rst rclass",   32'(result_class), 0);
        chk("rst rcycles",  32'(result_cycles), 0);
        chk("rst timeout",  32'(timeout_err), 0);
        chk_img("rst image", image, '0);
        rst = 1'b0;
        tick();

        // ---- full load, no stalls
        start    = 1'b1;
        img_data = img_a;
        w_valid  = 1'b1;
        w_data   = 8'd1;
        tick();
        start = 1'b0;
        chk("t1 busy", 32'(busy), 1);
        chk("t1 w_ready", 32'(w_ready), 1);
        chk("t1 kvalid idle", 32'(kernel_in_valid), 0);
        chk_img("t1 image", image, img_a);
        for (int i = 1; i <= 9; i++) begin
            w_data = 8'(i);
            tick();
            chk_write("t1 wr", i);
            if (i == 8) chk("t1 ivalid early", 32'(image_in_valid), 0);
        end
        w_valid = 1'b0;
        chk("t1 wloaded", 32'(weights_loaded), 1);
        chk("t1 ivalid", 32'(image_in_valid), 1);
        chk("t1 w_ready off", 32'(w_ready), 0);
        image_in_ready = 1'b1;
        tick();
        image_in_ready = 1'b0;
        chk("t1 ivalid drop", 32'(image_in_valid), 0);
        chk("t1 cready", 32'(class_out_ready), 1);
        class_out_valid = 1'b1;
        class_out       = 4'd3;
        tick();
        class_out_valid = 1'b0;
        chk("t1 rvalid", 32'(result_valid), 1);
        chk("t1 rclass", 32'(result_class), 3);
        chk("t1 rcycles", 32'(result_cycles), 1);
        chk("t1 busy end", 32'(busy), 0);
        tick();
        chk("t1 rvalid pulse", 32'(result_valid), 0);

        // ---- load with host stalls on alternate cycles
        start     = 1'b1;
        skip_load = 1'b0;
        img_data  = img_a;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            w_valid = 1'b0;
            tick();
            chk("t2 stall kvalid", 32'(kernel_in_valid), 0);
            w_valid = 1'b1;
            w_data  = 8'(i);
            tick();
            chk_write("t2 wr", i);
        end
        w_valid = 1'b0;
        chk("t2 ivalid", 32'(image_in_valid), 1);
        image_in_ready = 1'b1;
        tick();
        image_in_ready  = 1'b0;
        class_out_valid = 1'b1;
        class_out       = 4'd2;
        tick();
        class_out_valid = 1'b0;
        chk("t2 rclass", 32'(result_class), 2);
        tick();

        // ---- skip_load, delayed image_in_ready, class after 5 cycles
        start     = 1'b1;
        skip_load = 1'b1;
        img_data  = img_b;
        tick();
        start     = 1'b0;
        skip_load = 1'b0;
        img_data  = img_c;
        chk("t3 ivalid", 32'(image_in_valid), 1);
        chk("t3 w_ready", 32'(w_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3 ivalid hold", 32'(image_in_valid), 1);
            chk("t3 no kwrite", 32'(kernel_in_valid), 0);
            chk_img("t3 image hold", image, img_b);
        end
        image_in_ready = 1'b1;
        tick();
        image_in_ready = 1'b0;
        chk("t3 ivalid drop", 32'(image_in_valid), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3 rvalid wait", 32'(result_valid), 0);
        end
        class_out_valid = 1'b1;
        class_out       = 4'd7;
        tick();
        class_out_valid = 1'b0;
        chk("t3 rvalid", 32'(result_valid), 1);
        chk("t3 rclass", 32'(result_class), 7);
        chk("t3 rcycles", 32'(result_cycles), 5);
        chk("t3 busy end", 32'(busy), 0);
        chk("t3 timeout", 32'(timeout_err), 0);
        tick();
        chk("t3 rvalid pulse", 32'(result_valid), 0);
        chk("t3 rclass hold", 32'(result_class), 7);
        chk("t3 rcycles hold", 32'(result_cycles), 5);

        // ---- timeout: class never arrives
        start          = 1'b1;
        skip_load      = 1'b1;
        img_data       = img_b;
        image_in_ready = 1'b1;
        tick();
        start     = 1'b0;
        skip_load = 1'b0;
        tick();
        image_in_ready = 1'b0;
        chk("t4 cready", 32'(class_out_ready), 1);
        for (int i = 1; i <= 19; i++) begin
            tick();
            chk("t4 no timeout", 32'(timeout_err), 0);
            chk("t4 busy", 32'(busy), 1);
        end
        tick();
        chk("t4 timeout", 32'(timeout_err), 1);
        chk("t4 rvalid", 32'(result_valid), 0);
        chk("t4 busy end", 32'(busy), 0);
        tick();
        chk("t4 timeout pulse", 32'(timeout_err), 0);
        chk("t4 wloaded", 32'(weights_loaded), 1);
        chk("t4 rclass hold", 32'(result_class), 7);

        // ---- reset during LOAD2, then skip_load must still reload
        start     = 1'b1;
        skip_load = 1'b0;
        img_data  = img_a;
        w_valid   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            w_data = 8'(i);
            tick();
        end
        w_valid = 1'b0;
        chk("t5 in load2", 32'(kernel_layer), 2);
        rst = 1'b1;
        #1;
        chk("t5 rst busy", 32'(busy), 0);
        chk("t5 rst wloaded", 32'(weights_loaded), 0);
        chk("t5 rst kvalid", 32'(kernel_in_valid), 0);
        chk("t5 rst w_ready", 32'(w_ready), 0);
        chk_img("t5 rst image", image, '0);
        rst = 1'b0;
        tick();
        start     = 1'b1;
        skip_load = 1'b1;
        img_data  = img_d;
        tick();
        start     = 1'b0;
        skip_load = 1'b0;
        chk("t5 busy", 32'(busy), 1);
        chk("t5 w_ready", 32'(w_ready), 1);
        chk("t5 no ivalid", 32'(image_in_valid), 0);
        w_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            w_data = 8'(i);
            tick();
            if (i == 1) chk_write("t5 wr", i);
        end
        w_valid = 1'b0;
        chk("t5 wloaded", 32'(weights_loaded), 1);
        image_in_ready = 1'b1;
        tick();
        image_in_ready = 1'b0;

        // ---- start during WAIT_CLASS is ignored
        start    = 1'b1;
        img_data = img_c;
        tick();
        start = 1'b0;
        chk_img("t6 image kept", image, img_d);
        chk("t6 busy", 32'(busy), 1);
        chk("t6 w_ready", 32'(w_ready), 0);
        chk("t6 ivalid", 32'(image_in_valid), 0);
        class_out_valid = 1'b1;
        class_out       = 4'd9;
        tick();
        class_out_valid = 1'b0;
        chk("t6 rvalid", 32'(result_valid), 1);
        chk("t6 rclass", 32'(result_class), 9);
        chk("t6 rcycles", 32'(result_cycles), 2);
        tick();
        chk("t6 rvalid pulse", 32'(result_valid), 0);
        chk("t6 busy end", 32'(busy), 0);
        tick();
        chk("t6 one result", 32'(result_valid), 0);
        chk("t6 idle", 32'(busy), 0);
        chk_img("t6 image final", image, img_d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
